// File: rtl/alu_ctrl_stage_if.sv
// rtl/alu_ctrl_stage_if.sv - decode/execute handshake bundle for the ALU-op control stage
interface alu_ctrl_stage_if #(
    parameter int AOP_W = 4
);
    logic             valid_i;
    logic             ready_o;
    logic             r_type_i;
    logic             i_type_i;
    logic             store_i;
    logic             branch_i;
    logic             load_i;
    logic             jalr_i;
    logic             jal_i;
    logic             lui_i;
    logic             auipc_i;
    logic             m_ext_i;
    logic [2:0]       funct3_i;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic [AOP_W-1:0] aluop_o;
    logic             illegal_o;
    logic             busy_o;

    // The stage side: consumes decode flags and execute backpressure.
    modport slave (
        input  valid_i, r_type_i, i_type_i, store_i, branch_i, load_i,
               jalr_i, jal_i, lui_i, auipc_i, m_ext_i, funct3_i, flush_i, ready_i,
        output ready_o, valid_o, aluop_o, illegal_o, busy_o
    );

    // The environment side: decode, branch resolution and execute.
    modport master (
        output valid_i, r_type_i, i_type_i, store_i, branch_i, load_i,
               jalr_i, jal_i, lui_i, auipc_i, m_ext_i, funct3_i, flush_i, ready_i,
        input  ready_o, valid_o, aluop_o, illegal_o, busy_o
    );
endinterface

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - registered ALU-op decoder with M-extension occupancy gating
module alu_ctrl_stage #(
    parameter int AOP_W      = 4,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    alu_ctrl_stage_if.slave  bus
);
    localparam int MAX_LAT = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             valid_q;
    logic [AOP_W-1:0] aluop_q;
    logic             illegal_q;
    logic             busy_q;

    logic [3:0]       code;
    logic             code_illegal;
    logic             is_m_op;
    logic             is_div;
    logic             accept;
    logic             ready;

    // Class-flag priority encoder; m_ext only matters for R-type.
    always_comb begin
        code         = 4'b0000;
        code_illegal = 1'b0;
        if (bus.r_type_i) begin
            if (bus.m_ext_i) begin
                code = bus.funct3_i[2] ? 4'b1001 : 4'b1000;
            end else begin
                code = 4'b0000;
            end
        end else if (bus.load_i) begin
            code = 4'b0100;
        end else if (bus.store_i) begin
            code = 4'b0101;
        end else if (bus.branch_i) begin
            code = 4'b0010;
        end else if (bus.i_type_i) begin
            code = 4'b0001;
        end else if (bus.jalr_i || bus.jal_i) begin
            code = 4'b0011;
        end else if (bus.lui_i) begin
            code = 4'b0110;
        end else if (bus.auipc_i) begin
            code = 4'b0111;
        end else begin
            code         = 4'b1111;
            code_illegal = 1'b1;
        end
    end

    assign is_m_op = bus.r_type_i && bus.m_ext_i;
    assign is_div  = bus.funct3_i[2];

    // Issue only from IDLE and only when the output slot is free or draining now.
    assign ready  = (state == IDLE) && (!valid_q || bus.ready_i);
    assign accept = bus.valid_i && ready;

    // Pipeline register and M-op occupancy FSM; reset beats flush beats accept/WAIT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            count     <= '0;
            valid_q   <= 1'b0;
            aluop_q   <= '0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
        end else if (bus.flush_i) begin
            state     <= IDLE;
            count     <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (code_illegal) begin
                            aluop_q <= '1;
                        end else begin
                            aluop_q <= AOP_W'(code);
                        end
                        if (is_m_op) begin
                            // Result is only presented once the iterative unit is done.
                            illegal_q <= 1'b0;
                            valid_q   <= 1'b0;
                            busy_q    <= 1'b1;
                            count     <= is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                            state     <= WAIT;
                        end else begin
                            illegal_q <= code_illegal;
                            valid_q   <= 1'b1;
                        end
                    end else if (bus.ready_i) begin
                        valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (count == '0) begin
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o   = ready;
    assign bus.valid_o   = valid_q;
    assign bus.aluop_o   = aluop_q;
    assign bus.illegal_o = illegal_q;
    assign bus.busy_o    = busy_q;
endmodule
